// File: rtl/opTypes.sv
// opTypes: shared ALU operation encoding and the issue payload handed to the ALU.
package opTypes;
    typedef enum logic [3:0] {
        noALU, addALU, subALU, andALU, orALU, xorALU,
        sltALU, sltuALU, sllALU, srlALU, sraALU
    } ALU_operation_t;
    // Widest ROB tag the payload can carry; narrower tags are zero-extended.
    localparam int TAG_MAX_W = 16;
    typedef struct packed {
        ALU_operation_t       op;
        logic [31:0]          a;
        logic [31:0]          b;
        logic [31:0]          pc;
        logic [TAG_MAX_W-1:0] tag;
    } alu_issue_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: one-hot round-robin pick, searching upward from ptr and wrapping N-1 -> 0.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW:0] j;
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = '0;
        for (int i = 0; i < N; i++) begin
            j = {1'b0, ptr} + (IW+1)'(i);
            j = (j >= (IW+1)'(N)) ? j - (IW+1)'(N) : j;
            if (!any && req[j]) begin
                any      = 1'b1;
                idx      = j[IW-1:0];
                grant[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin issue of ready reservation-station entries into a one-deep ALU slot.
// Define ALU_ISSUE_PERF_EN to add the perf_issue_cnt / perf_stall_cnt counters.
module alu_issue_arbiter
    import opTypes::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  ALU_operation_t [NUM_REQ-1:0]    req_op,
    input  logic [NUM_REQ-1:0][31:0]        req_src1,
    input  logic [NUM_REQ-1:0][31:0]        req_src2,
    input  logic [NUM_REQ-1:0][31:0]        req_pc,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag,
    output logic [NUM_REQ-1:0]              req_grant,
    input  logic                            flush,
    output logic                            alu_valid,
    input  logic                            alu_ready,
    output ALU_operation_t                  alu_op,
    output logic [31:0]                     alu_a,
    output logic [31:0]                     alu_b,
    output logic [31:0]                     alu_pc,
    output logic [TAG_W-1:0]                alu_tag
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]                     perf_issue_cnt,
    output logic [31:0]                     perf_stall_cnt
`endif
);
    localparam int IW = $clog2(NUM_REQ);
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               can_accept;
    logic [NUM_REQ-1:0] pick_req;
    logic               unused_tag_bits;
    alu_issue_t         slot;
    assign can_accept = !alu_valid || alu_ready;
    // Masking the request vector keeps the grant low during reset, flush and stalls.
    assign pick_req   = (rst_n && can_accept && !flush) ? req_valid : '0;
    rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req   (pick_req),
        .ptr   (rr_ptr),
        .grant (req_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_valid <= 1'b0;
            rr_ptr    <= '0;
            slot      <= '{op: noALU, a: '0, b: '0, pc: '0, tag: '0};
        end else if (pick_any) begin
            alu_valid <= 1'b1;
            rr_ptr    <= (pick_idx == IW'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
            slot      <= '{op: req_op[pick_idx], a: req_src1[pick_idx], b: req_src2[pick_idx],
                           pc: req_pc[pick_idx], tag: TAG_MAX_W'(req_tag[pick_idx])};
        end else if (flush || alu_ready) begin
            alu_valid <= 1'b0;
        end
    end
    assign alu_op          = slot.op;
    assign alu_a           = slot.a;
    assign alu_b           = slot.b;
    assign alu_pc          = slot.pc;
    assign alu_tag         = slot.tag[TAG_W-1:0];
    assign unused_tag_bits = ^(slot.tag >> TAG_W);
`ifdef ALU_ISSUE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            perf_issue_cnt <= perf_issue_cnt + 32'(pick_any);
            perf_stall_cnt <= perf_stall_cnt + 32'(alu_valid && !alu_ready);
        end
    end
`endif
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: directed vector table, corner-case sequences and a randomized reference-model run.
module tb_alu_issue_arbiter;
    import opTypes::*;
    localparam int N = 4;
    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, alu_ready = 1'b0;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_grant;
    ALU_operation_t [N-1:0] req_op;
    logic [N-1:0][31:0] req_src1, req_src2, req_pc;
    logic [N-1:0][4:0] req_tag;
    logic alu_valid;
    ALU_operation_t alu_op;
    logic [31:0] alu_a, alu_b, alu_pc;
    logic [4:0] alu_tag;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif
    int errs = 0, checks = 0;
    // Reference model state: slot contents, next search start and event counts.
    logic m_valid;
    ALU_operation_t m_op;
    logic [31:0] m_a, m_b, m_pc;
    logic [4:0] m_tag;
    int m_ptr, m_issue, m_stall;

    typedef struct {
        logic [3:0] rv;
        logic       rdy;
        logic       fl;
        logic [3:0] g;
        logic       v;
    } vec_t;
    vec_t tbl [15];

    always #5 clk = ~clk;

    alu_issue_arbiter #(.NUM_REQ(N), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2), .req_pc(req_pc), .req_tag(req_tag),
        .req_grant(req_grant), .flush(flush), .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_pc(alu_pc), .alu_tag(alu_tag)
`ifdef ALU_ISSUE_PERF_EN
        , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_valid", 64'(alu_valid), 64'd0);
        chk("rst_grant", 64'(req_grant), 64'd0);
        chk("rst_op", 64'(alu_op), 64'(noALU));
        chk("rst_a", 64'(alu_a), 64'd0);
        chk("rst_b", 64'(alu_b), 64'd0);
        chk("rst_pc", 64'(alu_pc), 64'd0);
        chk("rst_tag", 64'(alu_tag), 64'd0);
`ifdef ALU_ISSUE_PERF_EN
        chk("rst_perf_issue", 64'(perf_issue_cnt), 64'd0);
        chk("rst_perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif
    endtask

    // Called and returns one time unit after a rising edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1 chk_reset_state();
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_valid = 1'b0; m_ptr = 0; m_issue = 0; m_stall = 0;
        m_op = noALU; m_a = '0; m_b = '0; m_pc = '0; m_tag = '0;
    endtask

    task automatic rand_payload();
        for (int i = 0; i < N; i++) begin
            req_op[i]   = ALU_operation_t'($urandom_range(0, 10));
            req_src1[i] = $urandom;
            req_src2[i] = $urandom;
            req_pc[i]   = $urandom;
            req_tag[i]  = 5'($urandom);
        end
    endtask

    task automatic model_cycle();
        int g;
        g = -1;
        #3;
        if (!flush && (!m_valid || alu_ready))
            for (int k = 0; k < N; k++)
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        chk("grant", 64'(req_grant), (g < 0) ? 64'd0 : (64'd1 << g));
        if (m_valid && !alu_ready) m_stall++;
        if (g >= 0) begin
            m_issue++;
            m_valid = 1'b1;
            m_op = req_op[g]; m_a = req_src1[g]; m_b = req_src2[g]; m_pc = req_pc[g]; m_tag = req_tag[g];
            m_ptr = (g + 1) % N;
        end else if (flush || alu_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("valid", 64'(alu_valid), 64'(m_valid));
        if (m_valid) begin
            chk("op", 64'(alu_op), 64'(m_op));
            chk("a", 64'(alu_a), 64'(m_a));
            chk("b", 64'(alu_b), 64'(m_b));
            chk("pc", 64'(alu_pc), 64'(m_pc));
            chk("tag", 64'(alu_tag), 64'(m_tag));
        end
    endtask

    task automatic step_expect(input string name, input logic [3:0] g, input logic v);
        #3 chk({name, "_grant"}, 64'(req_grant), 64'(g));
        @(posedge clk);
        #1 chk({name, "_valid"}, 64'(alu_valid), 64'(v));
    endtask

    initial begin
        tbl = '{
            '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1},
            '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1},
            '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1},
            '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1},
            '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1},
            '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1},
            '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1},
            '{4'b1001, 1'b1, 1'b0, 4'b1000, 1'b1},
            '{4'b1001, 1'b1, 1'b0, 4'b0001, 1'b1},
            '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0},
            '{4'b1000, 1'b0, 1'b0, 4'b1000, 1'b1},
            '{4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1},
            '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1},
            '{4'b1000, 1'b1, 1'b1, 4'b0000, 1'b0},
            '{4'b1010, 1'b1, 1'b0, 4'b0010, 1'b1}
        };
        rand_payload();
        #2 chk_reset_state();
        @(posedge clk);
        #1 rst_n = 1'b1;
        // Directed grant/valid table straight out of reset.
        for (int i = 0; i < 15; i++) begin
            req_valid = tbl[i].rv;
            alu_ready = tbl[i].rdy;
            flush     = tbl[i].fl;
            step_expect($sformatf("tbl%0d", i), tbl[i].g, tbl[i].v);
        end
        flush = 1'b0;
        // Single request payload transfer.
        req_valid = '0;
        apply_reset();
        req_valid = 4'b0100; alu_ready = 1'b1;
        req_op[2] = addALU; req_src1[2] = 32'd5; req_src2[2] = 32'd7; req_tag[2] = 5'd3;
        step_expect("single", 4'b0100, 1'b1);
        chk("single_a", 64'(alu_a), 64'd5);
        chk("single_b", 64'(alu_b), 64'd7);
        chk("single_tag", 64'(alu_tag), 64'd3);
        chk("single_op", 64'(alu_op), 64'(addALU));
        // Back-pressure: payload must hold while the ALU is not ready.
        alu_ready = 1'b0; req_valid = 4'b0011; req_src1[0] = 32'd99;
        for (int i = 0; i < 3; i++) begin
            step_expect("stall", 4'b0000, 1'b1);
            chk("stall_a", 64'(alu_a), 64'd5);
        end
`ifdef ALU_ISSUE_PERF_EN
        chk("stall_cnt", 64'(perf_stall_cnt), 64'd3);
        chk("issue_cnt1", 64'(perf_issue_cnt), 64'd1);
`endif
        alu_ready = 1'b1;
        step_expect("unstall", 4'b0001, 1'b1);
        chk("unstall_a", 64'(alu_a), 64'd99);
        // Flush beats ready and a pending request, and leaves the pointer alone.
        flush = 1'b1; req_valid = 4'b1000;
        step_expect("flush", 4'b0000, 1'b0);
        flush = 1'b0; req_valid = 4'b1001;
        step_expect("post_flush", 4'b1000, 1'b1);
`ifdef ALU_ISSUE_PERF_EN
        chk("issue_cnt2", 64'(perf_issue_cnt), 64'd3);
        chk("stall_cnt2", 64'(perf_stall_cnt), 64'd3);
`endif
        // Asynchronous reset with the slot occupied.
        alu_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_state();
        @(posedge clk);
        #1 rst_n = 1'b1; req_valid = 4'b1111; alu_ready = 1'b1;
        step_expect("after_rst", 4'b0001, 1'b1);
        // Randomized run against the reference model.
        req_valid = '0;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            rand_payload();
            req_valid = 4'($urandom);
            alu_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            model_cycle();
        end
`ifdef ALU_ISSUE_PERF_EN
        chk("rand_issue_cnt", 64'(perf_issue_cnt), 64'(m_issue));
        chk("rand_stall_cnt", 64'(perf_stall_cnt), 64'(m_stall));
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/alu_issue_arbiter.md
ALU_ISSUE_ARBITER -- requirements
Module: alu_issue_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of reservation-station requesters (2..8).
REQ-002 SHALL have parameter TAG_W, default 5, ROB tag width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester ready-to-issue.
REQ-006 SHALL have port req_op  input  NUM_REQ x ALU_operation_t  decoded ALU operation per requester.
REQ-007 SHALL have ports req_src1, req_src2, req_pc  input  NUM_REQ x 32  operands and instruction PC.
REQ-008 SHALL have port req_tag  input  NUM_REQ x TAG_W  ROB tag.
REQ-009 SHALL have port req_grant  output  NUM_REQ  one-hot combinational grant; requester retires its entry on the same edge.
REQ-010 SHALL have port flush  input  1  mispredict/exception squash.
REQ-011 SHALL have ports alu_valid output 1, alu_ready input 1  issue handshake toward the ALU.
REQ-012 SHALL have ports alu_op (ALU_operation_t), alu_a, alu_b, alu_pc (32), alu_tag (TAG_W)  output  registered issue payload.

Function
REQ-013 SHALL hold one registered issue slot (alu_valid plus payload); the slot can accept when empty or when alu_valid && alu_ready.
REQ-014 SHALL assert at most one req_grant bit, only when the slot can accept, flush is low, and that bit's req_valid is high.
REQ-015 SHALL select round-robin: search starts at rr_ptr, ascending with wrap NUM_REQ-1 -> 0.
REQ-016 SHALL set rr_ptr to (granted index + 1) mod NUM_REQ on a grant; unchanged otherwise.
REQ-017 SHALL load the granted requester's op/src1/src2/pc/tag into the slot and set alu_valid on the grant edge: latency grant -> alu_valid = 1 cycle.
REQ-018 SHALL keep payload and alu_valid stable while alu_valid && !alu_ready.
REQ-019 SHALL support back-to-back issue: alu_valid && alu_ready && new grant replaces the slot in the same edge, no bubble.
REQ-020 SHALL clear alu_valid when alu_ready && no grant.
REQ-021 SHALL on flush clear alu_valid at the next edge, suppress req_grant that cycle, leave rr_ptr unchanged; flush dominates simultaneous alu_ready and req_valid.
REQ-022 SHALL pass req_op unmodified, including noALU; no operation-dependent priority.
REQ-023 SHALL treat req_valid = 0 for all requesters as idle: no grant, slot drains per REQ-020.

Reset
REQ-024 SHALL on rst_n low immediately force alu_valid = 0, rr_ptr = 0, alu_op = noALU, alu_a/alu_b/alu_pc = 0, alu_tag = 0; req_grant = 0 while in reset.
REQ-025 SHALL grant normally on the first rising edge after rst_n deasserts; a reset mid-issue discards the slot.

Configuration
REQ-026 SHALL, with ALU_ISSUE_PERF_EN defined, add outputs perf_issue_cnt (32) counting grants and perf_stall_cnt (32) counting cycles with alu_valid && !alu_ready; both reset to 0, wrap at 2^32, not cleared by flush.
REQ-027 SHALL, without ALU_ISSUE_PERF_EN, omit both ports and counters; all other behaviour identical.

Structure
REQ-028 SHALL take ALU_operation_t (including noALU, addALU, subALU) from the shared opTypes package; alu_issue_t payload struct (op, a, b, pc, tag) SHALL be added there.
REQ-029 SHALL implement the round-robin pick in sub-module rr_picker (inputs req vector and rr_ptr; outputs one-hot grant and index).

Verification
REQ-030 SHALL test: req_valid=4'b1111, alu_ready=1 constantly, rr_ptr=0 -> grants 0,1,2,3,0 on consecutive cycles, alu_valid continuous from cycle 1.
REQ-031 SHALL test: req_valid=4'b0100, src1=5, src2=7, op=addALU, tag=3 -> grant 4'b0100, next cycle alu_valid=1, alu_a=5, alu_b=7, alu_tag=3.
REQ-032 SHALL test: slot full, alu_ready=0 for 3 cycles, req_valid=4'b0011 -> no grant, payload stable, perf_stall_cnt=3 (macro defined); alu_ready=1 -> grant 0 same cycle.
REQ-033 SHALL test: slot full, flush=1 with alu_ready=1 and req_valid=4'b1000 -> req_grant=0, alu_valid=0 next cycle, rr_ptr unchanged.
REQ-034 SHALL test: rst_n low mid-stream with alu_valid=1 -> alu_valid=0 immediately, after release first grant goes to requester 0.
REQ-035 SHALL test: rr_ptr=3, req_valid=4'b1001 -> grant requester 3, then requester 0 (wrap).
